// File: rtl/hcnt12.sv
// hcnt12: 12-bit programmable line/event counter that drives an external
// purely combinational magnitude comparator and turns its result into
// registered timing strobes.
//
// Optional feature macro: HCNT12_IRQ_EN (latched interrupt on hit).
//
// Ports
//   sys_clk    in   1   system clock, all state on rising edge
//   reset      in   1   synchronous active-high reset
//   cen        in   1   count enable
//   clr        in   1   synchronous counter clear (no wrap pulse)
//   din        in   12  write data for period / compare registers
//   ld_period  in   1   period <= din
//   ld_cmp     in   1   cmp_b  <= din
//   agb/aeb/alb in  1   comparator result for cnt vs cmp_b
//   irq_ack    in   1   interrupt acknowledge
//   cnt        out  12  counter value (comparator A operand)
//   cmp_b      out  12  compare register (comparator B operand)
//   wrap       out  1   pulse: counter wrapped at period
//   hit        out  1   pulse: counted past the compare value
//   win        out  1   level: cnt >= cmp_b, one cycle late
//   flag_err   out  1   sticky: comparator flags were not one-hot
//   irq        out  1   latched interrupt (0 when feature disabled)
module hcnt12 #(
    parameter logic [11:0] PERIOD_RST = 12'hFFF,
    parameter logic [11:0] CMP_RST    = 12'h000,
    localparam int unsigned W = 12
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         cen,
    input  logic         clr,
    input  logic [W-1:0] din,
    input  logic         ld_period,
    input  logic         ld_cmp,
    input  logic         agb,
    input  logic         aeb,
    input  logic         alb,
    input  logic         irq_ack,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cmp_b,
    output logic         wrap,
    output logic         hit,
    output logic         win,
    output logic         flag_err,
    output logic         irq
);

    logic [W-1:0] period;
    logic         at_period_c;
    logic         onehot_c;

    // Wrap uses the internal equality so a period set below cnt simply rolls
    // over through 12'hFFF without a wrap pulse.
    assign at_period_c = (cnt == period);

    // Exactly one flag set: odd parity and not all three.
    assign onehot_c = (agb ^ aeb ^ alb) & ~(agb & aeb & alb);

    // Counter, configuration registers and strobes.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt      <= '0;
            period   <= PERIOD_RST;
            cmp_b    <= CMP_RST;
            wrap     <= 1'b0;
            hit      <= 1'b0;
            win      <= 1'b0;
            flag_err <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (cen) begin
                if (at_period_c) begin
                    cnt  <= '0;
                    wrap <= 1'b1;
                end else begin
                    cnt <= cnt + W'(1);
                end
            end

            if (ld_period) begin
                period <= din;
            end
            if (ld_cmp) begin
                cmp_b <= din;
            end

            hit      <= cen & aeb & ~clr;
            win      <= agb | aeb;
            flag_err <= flag_err | ~onehot_c;
        end
    end

`ifdef HCNT12_IRQ_EN
    // Latched interrupt: a new hit overrides a simultaneous acknowledge.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (hit) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_ack;

    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_hcnt12.sv
// Bench for hcnt12: a cycle-level model derived from the counter's rules is
// compared against the DUT on every falling edge, plus directed scenarios
// with hand-computed literal expectations.
module tb_hcnt12;

    logic        sys_clk = 1'b0;
    logic        reset, cen, clr, ld_period, ld_cmp, irq_ack;
    logic [11:0] din;
    logic        agb, aeb, alb;
    logic [11:0] cnt, cmp_b;
    logic        wrap, hit, win, flag_err, irq;

    // Comparator override for fault injection
    logic        force_on;
    logic        f_agb, f_aeb, f_alb;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state
    int m_cnt, m_period, m_cmp;
    bit m_wrap, m_hit, m_win, m_err, m_irq;

    always #5 sys_clk = ~sys_clk;

    // External combinational comparator
    assign agb = force_on ? f_agb : (cnt >  cmp_b);
    assign aeb = force_on ? f_aeb : (cnt == cmp_b);
    assign alb = force_on ? f_alb : (cnt <  cmp_b);

    hcnt12 dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .cen      (cen),
        .clr      (clr),
        .din      (din),
        .ld_period(ld_period),
        .ld_cmp   (ld_cmp),
        .agb      (agb),
        .aeb      (aeb),
        .alb      (alb),
        .irq_ack  (irq_ack),
        .cnt      (cnt),
        .cmp_b    (cmp_b),
        .wrap     (wrap),
        .hit      (hit),
        .win      (win),
        .flag_err (flag_err),
        .irq      (irq)
    );

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: one step of the counter rules per rising edge
    always @(posedge sys_clk) begin
        bit g, e, l;
        int n_cnt;
        bit n_irq;
        if (force_on) begin
            g = f_agb; e = f_aeb; l = f_alb;
        end else begin
            g = m_cnt > m_cmp; e = m_cnt == m_cmp; l = m_cnt < m_cmp;
        end
        if (reset) begin
            m_cnt = 0; m_period = 4095; m_cmp = 0;
            m_wrap = 0; m_hit = 0; m_win = 0; m_err = 0; m_irq = 0;
        end else begin
`ifdef HCNT12_IRQ_EN
            n_irq = m_hit ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
`else
            n_irq = 1'b0;
`endif
            m_irq = n_irq;
            m_err = m_err || ((int'(g) + int'(e) + int'(l)) != 1);
            m_win = g || e;
            m_hit = cen && e && !clr;
            m_wrap = 0;
            n_cnt = m_cnt;
            if (clr) n_cnt = 0;
            else if (cen) begin
                if (m_cnt == m_period) begin
                    n_cnt = 0; m_wrap = 1;
                end else n_cnt = (m_cnt + 1) % 4096;
            end
            m_cnt = n_cnt;
            if (ld_period) m_period = int'(din);
            if (ld_cmp)    m_cmp    = int'(din);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("cnt",      cnt,            12'(m_cnt));
            chk("cmp_b",    cmp_b,          12'(m_cmp));
            chk("wrap",     12'(wrap),      12'(m_wrap));
            chk("hit",      12'(hit),       12'(m_hit));
            chk("win",      12'(win),       12'(m_win));
            chk("flag_err", 12'(flag_err),  12'(m_err));
            chk("irq",      12'(irq),       12'(m_irq));
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cen = 1'b0; clr = 1'b0; ld_period = 1'b0; ld_cmp = 1'b0;
        irq_ack = 1'b0; force_on = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input bit p, input bit c, input logic [11:0] v);
        din = v; ld_period = p; ld_cmp = c;
        tick();
        ld_period = 1'b0; ld_cmp = 1'b0;
    endtask

    initial begin
        int hits, hit_at, wraps, bad_wraps, n;
        reset = 1'b1; cen = 1'b0; clr = 1'b0; din = '0; ld_period = 1'b0;
        ld_cmp = 1'b0; irq_ack = 1'b0; force_on = 1'b0;
        f_agb = 1'b0; f_aeb = 1'b0; f_alb = 1'b0;

        // Reset state
        do_reset();
        chk_en = 1'b1;
        chk("rst_cnt", cnt, 12'h000);
        chk("rst_cmp", cmp_b, 12'h000);
        chk("rst_flags", {8'h0, wrap, hit, win, flag_err}, 12'h000);

        // cmp=5, count 8 cycles: one hit seen with cnt=6, win set
        load(1'b0, 1'b1, 12'd5);
        chk("ld_cmp", cmp_b, 12'd5);
        cen = 1'b1; hits = 0; hit_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (hit) begin hits++; hit_at = int'(cnt); end
        end
        chk("t1_hits", 12'(hits), 12'd1);
        chk("t1_hit_at", 12'(hit_at), 12'd6);
        chk("t1_cnt", cnt, 12'd8);
        chk("t1_win", 12'(win), 12'd1);

        // period=3: three wraps in 12 cycles, each with cnt back at 0
        do_reset();
        load(1'b1, 1'b0, 12'd3);
        cen = 1'b1; wraps = 0; bad_wraps = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (wrap) begin wraps++; if (cnt != 12'd0) bad_wraps++; end
        end
        chk("t2_wraps", 12'(wraps), 12'd3);
        chk("t2_bad_wraps", 12'(bad_wraps), 12'd0);

        // Period set below cnt: silent roll-over, then wraps at the new period
        do_reset();
        cen = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t3_cnt10", cnt, 12'd10);
        din = 12'd4; ld_period = 1'b1;
        tick();
        ld_period = 1'b0;
        chk("t3_cnt11", cnt, 12'd11);
        wraps = 0; n = 0;
        while (cnt != 12'd0 && n < 5000) begin
            tick(); n++;
            if (wrap) wraps++;
        end
        chk("t3_roll_bound", 12'(n < 5000), 12'd1);
        chk("t3_roll_len", 12'(n), 12'd4085);
        chk("t3_roll_wraps", 12'(wraps), 12'd0);
        wraps = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wrap) wraps++;
        end
        chk("t3_wraps", 12'(wraps), 12'd2);

        // Stall on cnt==cmp=2: no hit while stalled, one on resume
        do_reset();
        load(1'b0, 1'b1, 12'd2);
        cen = 1'b1;
        tick(); tick();
        chk("t4_cnt", cnt, 12'd2);
        cen = 1'b0; hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (hit) hits++;
        end
        chk("t4_hold", cnt, 12'd2);
        chk("t4_win", 12'(win), 12'd1);
        cen = 1'b1;
        tick();
        if (hit) hits++;
        tick();
        if (hit) hits++;
        chk("t4_hits", 12'(hits), 12'd1);

        // Comparator flags not one-hot: sticky error, counting unaffected
        do_reset();
        cen = 1'b1;
        tick(); tick();
        force_on = 1'b1; f_agb = 1'b1; f_aeb = 1'b1; f_alb = 1'b0;
        tick();
        force_on = 1'b0;
        chk("t5_err", 12'(flag_err), 12'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_err_sticky", 12'(flag_err), 12'd1);
        chk("t5_cnt", cnt, 12'd8);
        do_reset();
        chk("t5_err_rst", 12'(flag_err), 12'd0);

`ifdef HCNT12_IRQ_EN
        // Interrupt: rise after hit, set beats ack, lone ack clears, reset clears
        load(1'b1, 1'b1, 12'd3);
        load(1'b0, 1'b1, 12'd1);
        cen = 1'b1;
        tick(); tick();
        chk("t6_hit", 12'(hit), 12'd1);
        chk("t6_irq_lo", 12'(irq), 12'd0);
        tick();
        chk("t6_irq_hi", 12'(irq), 12'd1);
        tick(); tick(); tick();
        chk("t6_hit2", 12'(hit), 12'd1);
        irq_ack = 1'b1;
        tick();
        chk("t6_set_wins", 12'(irq), 12'd1);
        tick();
        irq_ack = 1'b0;
        chk("t6_ack_clr", 12'(irq), 12'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_cnt", cnt, 12'd0);
        chk("t6_rst_irq", 12'(irq), 12'd0);
        chk("t6_rst_win", 12'(win), 12'd0);
`else
        // Feature disabled: acknowledge has no effect, irq stays low
        load(1'b0, 1'b1, 12'd1);
        cen = 1'b1; irq_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        irq_ack = 1'b0;
        chk("t6_irq_off", 12'(irq), 12'd0);
`endif

        // clr beats cen and gives no wrap pulse
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t7_clr", cnt, 12'd0);
        chk("t7_clr_wrap", 12'(wrap), 12'd0);
        for (int i = 0; i < 3; i++) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
